// File: rtl/voting_pkg.sv
// Shared types and constants for the voting machine datapath.
// Pure declarations; no logic and no timing of its own.
package voting_pkg;

    localparam int NUM_CANDIDATES = 4;
    localparam int VOTE_W         = 8;
    localparam logic [VOTE_W-1:0] VOTE_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CAST,
        HOLD,
        COOLDOWN
    } logger_state_t;

    typedef logic [1:0] cand_idx_t;

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic cand_idx_t onehot_index(input logic [NUM_CANDIDATES-1:0] v);
        cand_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (v[i]) idx = cand_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser for one raw push button; 2-cycle latency, no backpressure.
// Both flops clear asynchronously so a reset also discards any press in flight.
module button_sync (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic synced
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= button;
            synced <= meta;
        end
    end

endmodule

// File: rtl/vote_logger.sv
// Turns raw candidate buttons into ballots and keeps four saturating tallies.
// Press-to-pulse is 3 edges after the sampling edge; no backpressure, ballots are paced by HOLD/COOLDOWN.
module vote_logger
    import voting_pkg::*;
#(
    parameter int COOLDOWN_CYCLES = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic              candidate1_button,
    input  logic              candidate2_button,
    input  logic              candidate3_button,
    input  logic              candidate4_button,
    output logic              valid_vote_casted,
    output logic [VOTE_W-1:0] candidate1_vote,
    output logic [VOTE_W-1:0] candidate2_vote,
    output logic [VOTE_W-1:0] candidate3_vote,
    output logic [VOTE_W-1:0] candidate4_vote,
    output logic              busy
);

    localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);

    logic [NUM_CANDIDATES-1:0] btn_raw;
    logic [NUM_CANDIDATES-1:0] btn_s;
    logic [2:0]                n_pressed;

    logger_state_t state, state_next;
    cand_idx_t     idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [VOTE_W-1:0] tally [NUM_CANDIDATES];

    assign btn_raw = {candidate4_button, candidate3_button, candidate2_button, candidate1_button};

    for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_sync
        button_sync u_sync (
            .clock  (clock),
            .reset  (reset),
            .button (btn_raw[g]),
            .synced (btn_s[g])
        );
    end

    assign n_pressed = 3'($countones(btn_s));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if (n_pressed == 3'd1) begin
                        state_next = CAST;
                        idx_next   = onehot_index(btn_s);
                    end else if (n_pressed > 3'd1) begin
                        state_next = HOLD;
                    end
                end
            end
            CAST: state_next = HOLD;
            HOLD: begin
                if (btn_s == '0) begin
                    cnt_next   = CNT_W'(COOLDOWN_CYCLES);
                    state_next = COOLDOWN;
                end
            end
            COOLDOWN: begin
                // A bounce or early re-press restarts the whole release/cooldown wait.
                if (btn_s != '0) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only the latched candidate can change, so at most one tally moves per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_vote_casted <= 1'b0;
            for (int i = 0; i < NUM_CANDIDATES; i++) tally[i] <= '0;
        end else begin
            valid_vote_casted <= 1'b0;
            if (state == CAST && tally[idx] != VOTE_MAX) begin
                tally[idx]        <= tally[idx] + VOTE_W'(1);
                valid_vote_casted <= 1'b1;
            end
        end
    end

    assign candidate1_vote = tally[0];
    assign candidate2_vote = tally[1];
    assign candidate3_vote = tally[2];
    assign candidate4_vote = tally[3];
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_vote_logger.sv
// Scoreboard bench for vote_logger: stimulus pushes expected pulses, a monitor pops and compares.
module tb_vote_logger;

    localparam int C = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       mode;
    logic [3:0] btns;
    logic       valid_vote_casted;
    logic [7:0] candidate1_vote, candidate2_vote, candidate3_vote, candidate4_vote;
    logic       busy;

    vote_logger #(.COOLDOWN_CYCLES(C)) dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .candidate1_button (btns[0]),
        .candidate2_button (btns[1]),
        .candidate3_button (btns[2]),
        .candidate4_button (btns[3]),
        .valid_vote_casted (valid_vote_casted),
        .candidate1_vote   (candidate1_vote),
        .candidate2_vote   (candidate2_vote),
        .candidate3_vote   (candidate3_vote),
        .candidate4_vote   (candidate4_vote),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int          cyc;
        logic [31:0] t;
    } exp_t;
    exp_t q[$];

    logic [7:0]  exp_tally [4];
    logic [31:0] tallies_now;
    assign tallies_now = {candidate4_vote, candidate3_vote, candidate2_vote, candidate1_vote};

    function automatic logic [31:0] exp_packed();
        return {exp_tally[3], exp_tally[2], exp_tally[1], exp_tally[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pulse for a press driven at the negedge where cyc==k is expected on the negedge where cyc==k+4.
    task automatic note_vote(input int cand, input int k);
        if (exp_tally[cand] != 8'hFF) begin
            exp_tally[cand]++;
            q.push_back('{k + 4, exp_packed()});
        end
    endtask

    task automatic press(input int cand, input int hold, input int gap, input bit counts);
        @(negedge clock);
        btns = 4'(1 << cand);
        if (counts) note_vote(cand, cyc);
        repeat (hold) @(negedge clock);
        btns = '0;
        repeat (gap) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (!reset && valid_vote_casted) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_pulse cycle=%0d tallies=%0h", cyc, tallies_now);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check("pulse_tallies", tallies_now, e.t);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int r;
        for (int i = 0; i < 4; i++) exp_tally[i] = '0;
        reset = 1'b1;
        mode  = 1'b0;
        btns  = '0;

        @(negedge clock);
        check("rst_valid", 32'(valid_vote_casted), 32'd0);
        check("rst_tallies", tallies_now, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_valid", 32'(valid_vote_casted), 32'd0);
        check("post_rst_tallies", tallies_now, 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Candidates 1 and 4 together: ambiguous, no vote.
        @(negedge clock);
        btns = 4'b1001;
        repeat (5) @(negedge clock);
        btns = '0;
        repeat (20) @(negedge clock);
        check("multi_tallies", tallies_now, 32'd0);

        // Result mode ignores presses.
        mode = 1'b1;
        press(2, 5, 20, 1'b0);
        check("mode1_cand3", 32'(candidate3_vote), 32'd0);
        check("mode1_busy", 32'(busy), 32'd0);
        mode = 1'b0;
        repeat (3) @(negedge clock);

        // Single vote for candidate 2 with busy timing: one HOLD cycle plus C cooldown cycles.
        @(negedge clock);
        k = cyc;
        btns = 4'b0010;
        note_vote(1, k);
        repeat (5) @(negedge clock);
        btns = '0;
        r = cyc;
        repeat (2 + C) @(negedge clock);
        check("busy_before_fall", 32'(busy), 32'd1);
        @(negedge clock);
        check("busy_after_fall", 32'(busy), 32'd0);
        check("single_tallies", tallies_now, 32'h0000_0100);
        repeat (5) @(negedge clock);

        // Three spaced presses, third followed by an early re-press that must be ignored.
        press(0, 5, 20, 1'b1);
        press(0, 5, 20, 1'b1);
        press(0, 5, 4, 1'b1);
        press(0, 3, 20, 1'b0);
        check("repeat_cand1", 32'(candidate1_vote), 32'd3);

        // Rises one cycle apart: candidate 2 first, so candidate 2 wins.
        @(negedge clock);
        k = cyc;
        btns = 4'b0010;
        note_vote(1, k);
        @(negedge clock);
        btns = 4'b0110;
        repeat (5) @(negedge clock);
        btns = '0;
        repeat (20) @(negedge clock);
        check("stagger_cand2", 32'(candidate2_vote), 32'd2);
        check("stagger_cand3", 32'(candidate3_vote), 32'd0);

        // Long hold: one pulse, FSM stays busy until release.
        @(negedge clock);
        k = cyc;
        btns = 4'b0010;
        note_vote(1, k);
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (i == 50 || i == 99) check("long_hold_busy", 32'(busy), 32'd1);
        end
        btns = '0;
        repeat (20) @(negedge clock);
        check("long_cand2", 32'(candidate2_vote), 32'd3);

        // Saturation of candidate 4: the 256th press is rejected.
        for (int i = 0; i < 256; i++) press(3, 3, 16, 1'b1);
        repeat (5) @(negedge clock);
        check("sat_cand4", 32'(candidate4_vote), 32'hFF);
        check("sat_all", tallies_now, 32'hFF00_0303);

        // Reset between edges while in CAST aborts the ballot.
        @(negedge clock);
        k = cyc;
        btns = 4'b0001;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", 32'(valid_vote_casted), 32'd0);
        check("midrst_tallies", tallies_now, 32'd0);
        btns = '0;
        for (int i = 0; i < 4; i++) exp_tally[i] = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        press(0, 5, 20, 1'b1);
        check("fresh_tallies", tallies_now, 32'h0000_0001);

        repeat (10) @(negedge clock);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
